// File: rtl/radix4_mul_sequencer.sv
// Sequential unsigned WIDTH x WIDTH multiplier that adds one radix-4 multiple {0, A, 2A, 3A} per cycle.
// Latency is fixed at WIDTH/2+2 cycles from accept to the done pulse; iStart is ignored while busy.
module radix4_mul_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 iStart,
   input  logic [WIDTH-1:0]     iA,
   input  logic [WIDTH-1:0]     iB,
   output logic                 oBusy,
   output logic                 oDone,
   output logic [2*WIDTH-1:0]   oResult,
   output logic [1:0]           oDigit
);
   localparam int STEPW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [WIDTH+1:0]     m3_q;
   logic [2*WIDTH-1:0]   acc_q, result_q;
   logic [STEPW-1:0]     step_q;

   logic [1:0]           digit;
   logic [WIDTH+1:0]     multiple;
   logic [2*WIDTH-1:0]   addend, acc_sum;
   logic                 last_step;

   always_comb begin
      digit = b_q[{step_q, 1'b0} +: 2];
      case (digit)
         2'b00:   multiple = '0;
         2'b01:   multiple = {2'b00, a_q};
         2'b10:   multiple = {1'b0, a_q, 1'b0};
         default: multiple = m3_q;
      endcase
      addend    = (2*WIDTH)'(multiple) << {step_q, 1'b0};
      acc_sum   = acc_q + addend;
      last_step = (step_q == STEPW'(WIDTH / 2 - 1));
   end

   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      oBusy     = 1'b1;
      oDone     = 1'b0;
      oDigit    = 2'b00;
      case (state)
         IDLE: begin
            oBusy = 1'b0;
            if (iStart) state_nxt = LOAD;
         end
         LOAD: state_nxt = RUN;
         RUN: begin
            oDigit = digit;
            if (last_step) state_nxt = DONE;
         end
         default: begin
            oDone     = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // The 3A multiple is precomputed once so each RUN cycle needs only one adder.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         a_q      <= '0;
         b_q      <= '0;
         m3_q     <= '0;
         acc_q    <= '0;
         step_q   <= '0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (iStart) begin
                  a_q <= iA;
                  b_q <= iB;
               end
            end
            LOAD: begin
               m3_q   <= {2'b00, a_q} + {1'b0, a_q, 1'b0};
               acc_q  <= '0;
               step_q <= '0;
            end
            RUN: begin
               acc_q  <= acc_sum;
               step_q <= step_q + STEPW'(1);
               if (last_step) result_q <= acc_sum;
            end
            default: ;
         endcase
      end
   end

   assign oResult = result_q;
endmodule
